// File: rtl/phase_window_counter_if.sv
// Phase inputs, window configuration and snapshot valid/ready port of
// phase_window_counter; slave is the counter's view, master the driver's.
interface phase_window_counter_if #(
  parameter int NUM_CH    = 11,
  parameter int CNT_WIDTH = 8,
  parameter int WIN_WIDTH = 16
);
  logic [NUM_CH-1:0]           data_i;
  logic [1:0]                  edge_mode_i;
  logic [WIN_WIDTH-1:0]        win_len_i;
  logic                        enable_i;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt_o;
  logic [NUM_CH-1:0]           sat_o;
  logic                        valid_o;
  logic                        ready_i;
  logic                        overrun_o;

  modport slave (
    input  data_i, edge_mode_i, win_len_i, enable_i, ready_i,
    output cnt_o, sat_o, valid_o, overrun_o
  );

  modport master (
    output data_i, edge_mode_i, win_len_i, enable_i, ready_i,
    input  cnt_o, sat_o, valid_o, overrun_o
  );
endinterface

// File: rtl/phase_window_counter.sv
// Windowed, saturating per-channel edge counter; each completed window's counts
// are offered as one snapshot on a registered valid/ready port.
module phase_window_counter #(
  parameter int NUM_CH    = 11,
  parameter int CNT_WIDTH = 8,
  parameter int WIN_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  phase_window_counter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [NUM_CH-1:0]           s1_q, s2_q;
  logic [1:0]                  prime_q;
  logic                        primed;
  logic [1:0]                  mode_q, mode_d;
  logic [WIN_WIDTH-1:0]        win_q, win_d, win_load;
  logic [CNT_WIDTH-1:0]        cnt_q   [NUM_CH];
  logic [CNT_WIDTH-1:0]        cnt_d   [NUM_CH];
  logic [CNT_WIDTH-1:0]        cnt_inc [NUM_CH];
  logic [NUM_CH-1:0]           sat_q, sat_d, sat_inc, edge_v;
  logic                        snap;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_cnt, cnt_o_q;
  logic [NUM_CH-1:0]           sat_o_q;
  logic                        valid_q, overrun_q, accept;

  assign primed   = prime_q[1];
  assign win_load = (bus.win_len_i == '0) ? WIN_WIDTH'(1) : bus.win_len_i;
  assign accept   = valid_q & bus.ready_i;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prime_q <= '0;
    end else begin
      s1_q <= bus.data_i;
      s2_q <= s1_q;
      if (!primed) prime_q <= prime_q + 2'd1;
    end
  end

  always_comb begin
    case (mode_q)
      2'b00:   edge_v = s1_q & ~s2_q;
      2'b01:   edge_v = ~s1_q & s2_q;
      2'b10:   edge_v = s1_q ^ s2_q;
      default: edge_v = '0;
    endcase
    if (!primed) edge_v = '0;
  end

  // Counts including this cycle's edges; also the snapshot payload.
  always_comb begin
    snap_cnt = '0;
    sat_inc  = sat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (edge_v[i]) begin
        if (cnt_q[i] == '1) sat_inc[i] = 1'b1;
        else                cnt_inc[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
      snap_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_inc[i];
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    win_d   = win_q;
    sat_d   = sat_q;
    snap    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) cnt_d[i] = cnt_q[i];
    case (state_q)
      IDLE: begin
        sat_d = '0;
        for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
        if (bus.enable_i) begin
          state_d = COUNT;
          win_d   = win_load;
          mode_d  = bus.edge_mode_i;
        end
      end
      COUNT: begin
        win_d = win_q - WIN_WIDTH'(1);
        sat_d = sat_inc;
        for (int i = 0; i < NUM_CH; i++) cnt_d[i] = cnt_inc[i];
        if (win_q == WIN_WIDTH'(1)) begin
          snap  = 1'b1;
          sat_d = '0;
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
          if (bus.enable_i) begin
            win_d  = win_load;
            mode_d = bus.edge_mode_i;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.enable_i) begin
          state_d = IDLE;
          sat_d   = '0;
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
        end
      end
    endcase
  end

  // NOTE: the counter array is a few flops, not RAM, so it resets with the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      win_q   <= '0;
      sat_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      win_q   <= win_d;
      sat_q   <= sat_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A held snapshot is only replaced when it is being accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o_q   <= '0;
      sat_o_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (snap && (!valid_q || accept)) begin
      cnt_o_q <= snap_cnt;
      sat_o_q <= sat_inc;
      valid_q <= 1'b1;
    end else if (snap) begin
      overrun_q <= 1'b1;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.cnt_o     = cnt_o_q;
  assign bus.sat_o     = sat_o_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_phase_window_counter.sv
// Bench for phase_window_counter: a window-level reference model counts edges
// from the recorded input history and predicts every registered output.
module tb_phase_window_counter;
  localparam int NC   = 11;
  localparam int CW   = 8;
  localparam int WW   = 16;
  localparam int MAXC = (1 << CW) - 1;
  localparam int OW   = 2 + NC + NC*CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phase_window_counter_if #(.NUM_CH(NC), .CNT_WIDTH(CW), .WIN_WIDTH(WW)) bus_if ();

  phase_window_counter #(.NUM_CH(NC), .CNT_WIDTH(CW), .WIN_WIDTH(WW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: sample history since reset plus the open window's span.
  logic [NC-1:0]    hist[$];
  int               n         = 0;
  bit               in_win    = 1'b0;
  int               win_start = 0;
  int               win_end   = 0;
  logic [1:0]       win_mode  = 2'b00;
  bit               m_snap    = 1'b0;
  logic [NC*CW-1:0] exp_cnt   = '0;
  logic [NC-1:0]    exp_sat   = '0;
  logic             exp_valid = 1'b0;
  logic             exp_ovr   = 1'b0;

  function automatic logic [OW-1:0] obs();
    return {bus_if.overrun_o, bus_if.valid_o, bus_if.sat_o, bus_if.cnt_o};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {exp_ovr, exp_valid, exp_sat, exp_cnt};
  endfunction

  // Edges of a window are the sample pairs (m-1, m-2) for m in (s, e];
  // nothing is counted before both pipeline samples come from after reset.
  function automatic void window_counts(input int s, input int e, input logic [1:0] md,
                                        output logic [NC*CW-1:0] cv, output logic [NC-1:0] sv);
    logic [NC-1:0] cur, prev;
    logic          hit;
    int            total;
    cv = '0;
    sv = '0;
    for (int ch = 0; ch < NC; ch++) begin
      total = 0;
      for (int m = s + 1; m <= e; m++) begin
        if (m >= 3) begin
          cur  = hist[m-1];
          prev = hist[m-2];
          case (md)
            2'b00:   hit = cur[ch] & ~prev[ch];
            2'b01:   hit = ~cur[ch] & prev[ch];
            2'b10:   hit = cur[ch] ^ prev[ch];
            default: hit = 1'b0;
          endcase
          if (hit) total++;
        end
      end
      cv[ch*CW +: CW] = (total > MAXC) ? CW'(MAXC) : CW'(total);
      sv[ch]          = (total > MAXC);
    end
  endfunction

  task automatic model_edge();
    logic [NC*CW-1:0] s_cnt;
    logic [NC-1:0]    s_sat;
    bit               was_in;
    int               w;
    m_snap = 1'b0;
    s_cnt  = '0;
    s_sat  = '0;
    if (rst) begin
      n = 0;
      hist.delete();
      hist.push_back('0);
      in_win    = 1'b0;
      exp_cnt   = '0;
      exp_sat   = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      n++;
      hist.push_back(bus_if.data_i);
      w      = (bus_if.win_len_i == '0) ? 1 : int'(bus_if.win_len_i);
      was_in = in_win;
      if (was_in && n == win_end) begin
        window_counts(win_start, win_end, win_mode, s_cnt, s_sat);
        m_snap = 1'b1;
        in_win = 1'b0;
      end else if (was_in && !bus_if.enable_i) begin
        in_win = 1'b0;
      end
      if (bus_if.enable_i && (!was_in || m_snap)) begin
        in_win    = 1'b1;
        win_start = n;
        win_end   = n + w;
        win_mode  = bus_if.edge_mode_i;
      end
      if (m_snap) begin
        if (!exp_valid || bus_if.ready_i) begin
          exp_cnt   = s_cnt;
          exp_sat   = s_sat;
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && bus_if.ready_i) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    bus_if.enable_i = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.enable_i    = 1'b0;
    bus_if.ready_i     = 1'b0;
    bus_if.edge_mode_i = 2'b00;
    bus_if.win_len_i   = WW'(4);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bus_if.data_i = t[0] ? '1 : '0;
      tick();
      tests++;
      if (obs() !== '0) begin
        failed++;
        $display("FAIL reset_outputs t=%0d got=%h want=0", t, obs());
      end
    end
    rst = 1'b0;
    bus_if.enable_i    = 1'b1;
    bus_if.edge_mode_i = 2'b10;
    for (int t = 1; t <= 6; t++) begin
      bus_if.data_i = t[0] ? '1 : '0;
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL reset_model t=%0d got=%h want=%h", t, obs(), expv());
      end
      if (t == 5) begin
        tests++;
        if (bus_if.valid_o !== 1'b1 || bus_if.cnt_o[0 +: CW] !== CW'(3)) begin
          failed++;
          $display("FAIL prime_mask valid=%b ch0=%0d want valid=1 ch0=3",
                   bus_if.valid_o, bus_if.cnt_o[0 +: CW]);
        end
      end
    end
  endtask

  task automatic test_basic(input logic [1:0] mode, input int e0, input int e1);
    logic [NC-1:0] d;
    apply_reset(2);
    bus_if.edge_mode_i = mode;
    bus_if.win_len_i   = WW'(16);
    bus_if.ready_i     = 1'b1;
    for (int t = -2; t <= 81; t++) begin
      d    = NC'($urandom);
      d[0] = t[0];
      d[1] = ~t[1];
      d[2] = 1'b1;
      d[3] = 1'b0;
      bus_if.data_i   = d;
      bus_if.enable_i = (t >= 1);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL basic_model mode=%0d t=%0d got=%h want=%h", mode, t, obs(), expv());
      end
      if (m_snap) begin
        tests++;
        if (bus_if.cnt_o[0 +: CW] !== CW'(e0) || bus_if.cnt_o[CW +: CW] !== CW'(e1) ||
            bus_if.cnt_o[2*CW +: CW] !== '0 || bus_if.cnt_o[3*CW +: CW] !== '0 ||
            bus_if.sat_o[3:0] !== 4'h0) begin
          failed++;
          $display("FAIL basic_counts mode=%0d t=%0d got=%0d,%0d,%0d,%0d sat=%b want=%0d,%0d,0,0 sat=0000",
                   mode, t, bus_if.cnt_o[0 +: CW], bus_if.cnt_o[CW +: CW], bus_if.cnt_o[2*CW +: CW],
                   bus_if.cnt_o[3*CW +: CW], bus_if.sat_o[3:0], e0, e1);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [NC-1:0] d;
    int            snaps;
    snaps = 0;
    apply_reset(2);
    bus_if.edge_mode_i = 2'b10;
    bus_if.win_len_i   = WW'(300);
    bus_if.ready_i     = 1'b1;
    for (int t = -2; t <= 601; t++) begin
      d    = '0;
      d[0] = (t <= 290) ? t[0] : 1'b0;
      bus_if.data_i   = d;
      bus_if.enable_i = (t >= 1);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL sat_model t=%0d got=%h want=%h", t, obs(), expv());
      end
      if (m_snap) begin
        snaps++;
        tests++;
        if (snaps == 1 && (bus_if.cnt_o[0 +: CW] !== CW'(MAXC) || bus_if.sat_o !== NC'(1))) begin
          failed++;
          $display("FAIL sat_full ch0=%0d sat=%b want ch0=%0d sat=1 on ch0 only",
                   bus_if.cnt_o[0 +: CW], bus_if.sat_o, MAXC);
        end
        if (snaps == 2 && (bus_if.cnt_o[0 +: CW] !== '0 || bus_if.sat_o !== '0)) begin
          failed++;
          $display("FAIL sat_clear ch0=%0d sat=%b want ch0=0 sat=0",
                   bus_if.cnt_o[0 +: CW], bus_if.sat_o);
        end
      end
    end
  endtask

  task automatic test_backpressure(input int rise);
    logic want_valid;
    want_valid = ((rise % 8) == 1);
    apply_reset(2);
    bus_if.edge_mode_i = 2'b10;
    bus_if.win_len_i   = WW'(8);
    for (int t = -2; t <= 30; t++) begin
      bus_if.data_i   = NC'($urandom);
      bus_if.enable_i = (t >= 1);
      bus_if.ready_i  = (t >= rise);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL bp_model rise=%0d t=%0d got=%h want=%h", rise, t, obs(), expv());
      end
      if (t == 16 || t == 17) begin
        tests++;
        if (bus_if.overrun_o !== (t == 17)) begin
          failed++;
          $display("FAIL bp_overrun t=%0d got=%b want=%b", t, bus_if.overrun_o, (t == 17));
        end
      end
      if (t == rise) begin
        tests++;
        if (bus_if.valid_o !== want_valid) begin
          failed++;
          $display("FAIL bp_handshake rise=%0d got=%b want=%b", rise, bus_if.valid_o, want_valid);
        end
      end
    end
  endtask

  task automatic test_abort();
    apply_reset(2);
    bus_if.edge_mode_i = 2'b10;
    bus_if.win_len_i   = WW'(10);
    bus_if.ready_i     = 1'b1;
    for (int t = -2; t <= 26; t++) begin
      bus_if.data_i   = NC'($urandom);
      bus_if.enable_i = (t >= 1 && t <= 5) || (t >= 15);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL abort_model t=%0d got=%h want=%h", t, obs(), expv());
      end
      if (t < 25) begin
        tests++;
        if (bus_if.valid_o !== 1'b0) begin
          failed++;
          $display("FAIL abort_no_valid t=%0d got=%b want=0", t, bus_if.valid_o);
        end
      end
    end
  endtask

  task automatic test_short_windows(input int wl);
    apply_reset(2);
    bus_if.edge_mode_i = 2'b10;
    bus_if.win_len_i   = WW'(wl);
    bus_if.ready_i     = 1'b1;
    for (int t = -2; t <= 40; t++) begin
      bus_if.data_i   = NC'($urandom);
      bus_if.enable_i = (t >= 1);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL short_model wl=%0d t=%0d got=%h want=%h", wl, t, obs(), expv());
      end
      if (t >= 2) begin
        tests++;
        if (bus_if.valid_o !== 1'b1 || bus_if.overrun_o !== 1'b0) begin
          failed++;
          $display("FAIL short_stream wl=%0d t=%0d valid=%b ovr=%b want valid=1 ovr=0",
                   wl, t, bus_if.valid_o, bus_if.overrun_o);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [NC-1:0] d;
    apply_reset(2);
    bus_if.edge_mode_i = 2'b10;
    bus_if.win_len_i   = WW'(12);
    bus_if.ready_i     = 1'b0;
    for (int t = -2; t <= 18; t++) begin
      d    = NC'($urandom);
      d[0] = t[0];
      bus_if.data_i   = d;
      bus_if.enable_i = (t >= 1);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL midrst_model t=%0d got=%h want=%h", t, obs(), expv());
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (obs() !== '0) begin
      failed++;
      $display("FAIL midrst_clear got=%h want=0", obs());
    end
    bus_if.ready_i = 1'b1;
    for (int t = -2; t <= 13; t++) begin
      d    = NC'($urandom);
      d[0] = t[0];
      bus_if.data_i   = d;
      bus_if.enable_i = (t >= 1);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL midrst_restart t=%0d got=%h want=%h", t, obs(), expv());
      end
      if (t == 13) begin
        tests++;
        if (bus_if.valid_o !== 1'b1 || bus_if.cnt_o[0 +: CW] !== CW'(12)) begin
          failed++;
          $display("FAIL midrst_full valid=%b ch0=%0d want valid=1 ch0=12",
                   bus_if.valid_o, bus_if.cnt_o[0 +: CW]);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset(2);
    for (int t = 0; t < 3000; t++) begin
      bus_if.data_i      = NC'($urandom);
      bus_if.enable_i    = ($urandom_range(0, 19) != 0);
      bus_if.edge_mode_i = 2'($urandom);
      bus_if.win_len_i   = WW'($urandom_range(0, 12));
      bus_if.ready_i     = ($urandom_range(0, 9) < 6);
      rst                = ($urandom_range(0, 299) == 0);
      tick();
      tests++;
      if (obs() !== expv()) begin
        failed++;
        $display("FAIL random_model t=%0d got=%h want=%h", t, obs(), expv());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus_if.data_i      = '0;
    bus_if.enable_i    = 1'b0;
    bus_if.edge_mode_i = 2'b00;
    bus_if.win_len_i   = '0;
    bus_if.ready_i     = 1'b0;
    hist.push_back('0);
    test_reset();
    test_basic(2'b00, 8, 4);
    test_basic(2'b10, 16, 8);
    test_saturation();
    test_backpressure(21);
    test_backpressure(25);
    test_abort();
    test_short_windows(0);
    test_short_windows(1);
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
